fifo_level_monitor: RTL
=======================

# fifo_level_monitor

Registered occupancy and threshold monitor for the bridge FIFOs, parametrised in depth. It takes an (ADDRBITS+1)-bit binary write pointer already synchronised into this clock domain, plus the local read pointer. It produces:
- used and free counts, full, empty, almost-full and almost-empty flags;
- a level-zone state machine with change pulses;
- a high-watermark register and a sticky pointer-error flag.

It sits beside each async FIFO on the read side. It replaces ad-hoc free-space arithmetic with values that are correct at every depth and at pointer wrap.

## Interface
- ADDRBITS, 4: FIFO address bits. DEPTH = 2**ADDRBITS.
- clk  in  1: sole clock.
- rst  in  1: reset, synchronous and active-high.
- wr_ptr_sync  in  ADDRBITS+1: binary write pointer, synchronised to clk, MSB is the wrap bit.
- rd_ptr  in  ADDRBITS+1: binary read pointer, MSB is the wrap bit.
- af_thresh  in  ADDRBITS+1: almost-full threshold (used count).
- ae_thresh  in  ADDRBITS+1: almost-empty threshold (used count).
- wm_clr  in  1: clear high watermark, one-cycle pulse.
- err_clr  in  1: clear sticky pointer error, one-cycle pulse.
- used_cnt  out  ADDRBITS+1: occupied locations, 0..DEPTH.
- free_cnt  out  ADDRBITS+1: empty locations, DEPTH-used_cnt.
- empty, full, almost_empty, almost_full  out  1 each: level flags.
- zone  out  3: current level zone encoding.
- zone_chg  out  1: one-cycle pulse when zone changes.
- high_wm  out  ADDRBITS+1: maximum used_cnt since reset or wm_clr.
- ptr_err  out  1: sticky, set when pointer difference is impossible.

## Operation
- diff = (wr_ptr_sync - rd_ptr) modulo 2**(ADDRBITS+1), computed in ADDRBITS+1 bits; wrap handled by the MSB.
- diff <= DEPTH is valid.
  - Next cycle: used_cnt=diff, free_cnt=DEPTH-diff.
  - empty = (diff==0); full = (diff==DEPTH).
  - almost_full = (diff >= af_thresh); almost_empty = (diff <= ae_thresh).
- diff > DEPTH is invalid.
  - ptr_err sets.
  - All count, flag, zone and watermark registers hold their previous values.
- Zone FSM states: Z_EMPTY (used==0), Z_LOW (0<used<=ae_thresh), Z_MID, Z_HIGH (af_thresh<=used<DEPTH), Z_FULL (used==DEPTH).
  - Zone is recomputed from the valid new used value each cycle; jumps between any two states in one cycle are legal.
  - Priority: EMPTY > FULL > LOW > HIGH > MID. This resolves thresholds that overlap or are out of range.
  - zone_chg pulses on the cycle zone takes a different value.
- high_wm:
  - Updates to the new used_cnt when that value is greater than the current high_wm.
  - wm_clr loads the current valid used value, not 0.
  - If wm_clr and a larger used value occur together, the larger used value wins (clear-then-compare).
- ptr_err:
  - err_clr clears it.
  - A simultaneous err_clr and invalid diff leaves ptr_err = 1 (set wins).
- Thresholds are sampled every cycle; a change takes effect on the next registered update.

## Timing
- Latency is 1 clk from wr_ptr_sync/rd_ptr/thresholds to every output; there is no combinational input-to-output path.
- Reset values:
  - used_cnt=0, free_cnt=DEPTH, empty=1, full=0.
  - almost_empty=1, almost_full=0 (independent of thresholds during reset).
  - zone=Z_EMPTY, zone_chg=0, high_wm=0, ptr_err=0.
- Reset asserted mid-operation forces the reset values on the next edge, overriding all other inputs. zone_chg does not pulse on the first cycle after reset.
- Pointer wrap: wr=0x01, rd=0x1F (ADDRBITS=4) gives used=2, with no discontinuity in any output.

## Structure
- Package fifo_level_pkg holds:
  - zone encoding constants Z_EMPTY=0, Z_LOW=1, Z_MID=2, Z_HIGH=3, Z_FULL=4;
  - a function returning DEPTH from ADDRBITS.
- Sub-module fifo_level_calc: purely combinational diff, validity and zone decode. The top holds all registers, the watermark and the error logic.
- The same block instantiates on the write side with the pointer roles swapped; no mode parameter.

## Test plan
- Reset with ADDRBITS=4: after rst, used=0, free=16, empty=1, almost_empty=1, zone=Z_EMPTY, high_wm=0, ptr_err=0.
- Fill: step wr 0->16 with rd=0, af=12, ae=3.
  - almost_full rises the cycle after wr=12.
  - full and Z_FULL at used=16, free=0.
  - zone_chg pulses at used 1, 4, 12 and 16.
- Wrap: hold the difference at 5 while advancing both pointers through 0x1F->0x00; used stays 5 with no zone_chg pulse.
- Error: wr=0x14, rd=0x02 (diff 18) sets ptr_err and outputs hold. Then err_clr with a valid diff clears it; err_clr with an invalid diff keeps it set.
- Watermark:
  - Reach used=9, then drain to 2: high_wm=9.
  - wm_clr at used 2: high_wm becomes 2.
  - wm_clr in the same cycle as used=7: high_wm becomes 7.
- Reset mid-fill at used=10: the next cycle shows the reset values and no zone_chg.

Source files
------------

// File: rtl/fifo_level_pkg.sv
// Shared types and helpers for the FIFO level monitor.
package fifo_level_pkg;

  typedef enum logic [2:0] {
    Z_EMPTY = 3'd0,
    Z_LOW   = 3'd1,
    Z_MID   = 3'd2,
    Z_HIGH  = 3'd3,
    Z_FULL  = 3'd4
  } zone_t;

  function automatic int unsigned depth_of(input int unsigned addrbits);
    return 32'd1 << addrbits;
  endfunction

endpackage

// File: rtl/fifo_level_calc.sv
// Combinational occupancy decode: pointer difference, validity, flags and zone.
module fifo_level_calc
  import fifo_level_pkg::*;
#(
  parameter int unsigned ADDRBITS = 4
) (
  input  logic [ADDRBITS:0] i_wr_ptr,
  input  logic [ADDRBITS:0] i_rd_ptr,
  input  logic [ADDRBITS:0] i_af_thresh,
  input  logic [ADDRBITS:0] i_ae_thresh,
  output logic [ADDRBITS:0] o_diff,
  output logic [ADDRBITS:0] o_free,
  output logic              o_valid,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_almost_empty,
  output logic              o_almost_full,
  output zone_t             o_zone
);

  localparam logic [ADDRBITS:0] L_DEPTH = (ADDRBITS+1)'(depth_of(ADDRBITS));

  logic [ADDRBITS:0] w_diff;

  // Modular difference; the MSB wrap bit makes it correct across pointer wrap.
  always_comb begin
    w_diff         = i_wr_ptr - i_rd_ptr;
    o_diff         = w_diff;
    o_free         = L_DEPTH - w_diff;
    o_valid        = (w_diff <= L_DEPTH);
    o_empty        = (w_diff == '0);
    o_full         = (w_diff == L_DEPTH);
    o_almost_full  = (w_diff >= i_af_thresh);
    o_almost_empty = (w_diff <= i_ae_thresh);
  end

  // Zone decode; the if-chain order settles overlapping or out-of-range thresholds.
  always_comb begin
    o_zone = Z_MID;
    if (w_diff == '0)               o_zone = Z_EMPTY;
    else if (w_diff == L_DEPTH)     o_zone = Z_FULL;
    else if (w_diff <= i_ae_thresh) o_zone = Z_LOW;
    else if (w_diff >= i_af_thresh) o_zone = Z_HIGH;
  end

endmodule

// File: rtl/fifo_level_monitor.sv
// Registered FIFO occupancy/threshold monitor with zone FSM, watermark and pointer-error flag.
module fifo_level_monitor
  import fifo_level_pkg::*;
#(
  parameter int unsigned ADDRBITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDRBITS:0]   wr_ptr_sync,
  input  logic [ADDRBITS:0]   rd_ptr,
  input  logic [ADDRBITS:0]   af_thresh,
  input  logic [ADDRBITS:0]   ae_thresh,
  input  logic                wm_clr,
  input  logic                err_clr,
  output logic [ADDRBITS:0]   used_cnt,
  output logic [ADDRBITS:0]   free_cnt,
  output logic                empty,
  output logic                full,
  output logic                almost_empty,
  output logic                almost_full,
  output logic [2:0]          zone,
  output logic                zone_chg,
  output logic [ADDRBITS:0]   high_wm,
  output logic                ptr_err
);

  localparam logic [ADDRBITS:0] L_DEPTH = (ADDRBITS+1)'(depth_of(ADDRBITS));

  logic [ADDRBITS:0] w_diff, w_free, w_hw_base, w_hw_next;
  logic              w_valid, w_empty, w_full, w_ae, w_af;
  zone_t             w_zone_dec, w_zone_nxt;

  logic [ADDRBITS:0] r_used, r_free, r_hw;
  logic              r_empty, r_full, r_ae, r_af, r_zone_chg, r_err;
  zone_t             r_zone;

  fifo_level_calc #(.ADDRBITS(ADDRBITS)) u_calc (
    .i_wr_ptr       (wr_ptr_sync),
    .i_rd_ptr       (rd_ptr),
    .i_af_thresh    (af_thresh),
    .i_ae_thresh    (ae_thresh),
    .o_diff         (w_diff),
    .o_free         (w_free),
    .o_valid        (w_valid),
    .o_empty        (w_empty),
    .o_full         (w_full),
    .o_almost_empty (w_ae),
    .o_almost_full  (w_af),
    .o_zone         (w_zone_dec)
  );

  // Zone state register.
  always_ff @(posedge clk) begin
    if (rst) r_zone <= Z_EMPTY;
    else     r_zone <= w_zone_nxt;
  end

  // Next zone: follow the decode on a valid difference, hold otherwise.
  always_comb begin
    w_zone_nxt = r_zone;
    if (w_valid) w_zone_nxt = w_zone_dec;
  end

  // Zone outputs.
  always_comb begin
    zone     = r_zone;
    zone_chg = r_zone_chg;
  end

  // Watermark: clear-then-compare, so a clear still lets the new used value win.
  always_comb begin
    w_hw_base = wm_clr ? w_diff : r_hw;
    w_hw_next = (w_diff > w_hw_base) ? w_diff : w_hw_base;
  end

  // Count, flag and watermark registers; an impossible difference freezes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_used     <= '0;
      r_free     <= L_DEPTH;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_ae       <= 1'b1;
      r_af       <= 1'b0;
      r_hw       <= '0;
      r_zone_chg <= 1'b0;
    end else begin
      r_zone_chg <= (w_zone_nxt != r_zone);
      if (w_valid) begin
        r_used  <= w_diff;
        r_free  <= w_free;
        r_empty <= w_empty;
        r_full  <= w_full;
        r_ae    <= w_ae;
        r_af    <= w_af;
        r_hw    <= w_hw_next;
      end
    end
  end

  // Sticky pointer error; a new error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)           r_err <= 1'b0;
    else if (!w_valid) r_err <= 1'b1;
    else if (err_clr)  r_err <= 1'b0;
  end

  always_comb begin
    used_cnt     = r_used;
    free_cnt     = r_free;
    empty        = r_empty;
    full         = r_full;
    almost_empty = r_ae;
    almost_full  = r_af;
    high_wm      = r_hw;
    ptr_err      = r_err;
  end

endmodule
